// File: rtl/pkt_buf_pkg.sv
// Shared types for the router packet buffer: per-slot lifecycle state and
// the write-side FSM state.
package pkt_buf_pkg;

    // Lifecycle of one packet slot: allocated for writing, then readable,
    // then returned to the pool by an explicit release.
    typedef enum logic [1:0] {
        FREE      = 2'd0,
        FILLING   = 2'd1,
        COMMITTED = 2'd2
    } slot_state_t;

    // Write FSM: ALLOC opens a slot, FILL streams bytes into it.
    typedef enum logic {
        ALLOC = 1'b0,
        FILL  = 1'b1
    } wr_state_t;

endpackage : pkt_buf_pkg

// File: rtl/pkt_buf_slot_alloc.sv
// Lowest-index FREE slot finder used by the write FSM to open the next slot.
module pkt_buf_slot_alloc
    import pkt_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PTR_SZ = $clog2(DEPTH)
) (
    input  slot_state_t             slot_state [DEPTH],
    output logic                    found,
    output logic [PTR_SZ-1:0]       idx
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        // NOTE: every output gets a default before the loop; without it the
        // "no FREE slot" path would leave them unassigned and infer latches.
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (slot_state[i] == FREE) begin
                found = 1'b1;
                idx   = PTR_SZ'(i);
            end
        end
    end

endmodule : pkt_buf_slot_alloc

// File: rtl/router_packet_buffer.sv
// Slot-based packet store for the router input stage.
// One byte-serial write port fills slots, NRD independent read ports fetch
// bytes of committed slots with one cycle of latency, and a release port
// returns slots to the free pool.
// Optional feature macro: PKT_BUF_PARITY_EN adds an even-parity bit per
// stored byte and a per-port rd_perr output.
module router_packet_buffer
    import pkt_buf_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WIDTH     = 11,
    parameter int UWIDTH    = 8,
    parameter int NRD       = 3,
    parameter int PTR_SZ    = $clog2(DEPTH),
    parameter int PTR_IN_SZ = $clog2(WIDTH),
    parameter int LEN_SZ    = $clog2(WIDTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    // write port
    input  logic                     wr_valid,
    input  logic [UWIDTH-1:0]        wr_data,
    input  logic                     wr_last,
    output logic                     wr_ready,
    output logic [PTR_SZ-1:0]        wr_slot,
    output logic                     commit_vld,
    output logic [PTR_SZ-1:0]        commit_slot,
    output logic [LEN_SZ-1:0]        commit_len,
    output logic                     wr_trunc,
    // read ports
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*PTR_SZ-1:0]    rd_slot,
    input  logic [NRD*PTR_IN_SZ-1:0] rd_idx,
    output logic [NRD*UWIDTH-1:0]    rd_data,
    output logic [NRD-1:0]           rd_valid,
`ifdef PKT_BUF_PARITY_EN
    output logic [NRD-1:0]           rd_perr,
`endif
    // release port and occupancy
    input  logic                     rel_en,
    input  logic [PTR_SZ-1:0]        rel_slot,
    output logic                     rel_err,
    output logic [PTR_SZ:0]          free_cnt,
    output logic                     full
);

`ifdef PKT_BUF_PARITY_EN
    localparam int MEM_W = UWIDTH + 1;
`else
    localparam int MEM_W = UWIDTH;
`endif
    localparam logic [PTR_IN_SZ-1:0] CNT_LAST = PTR_IN_SZ'(WIDTH - 1);

    wr_state_t              wr_state_q, wr_state_d;
    slot_state_t            slot_state_q [DEPTH];
    slot_state_t            slot_state_d [DEPTH];
    logic [LEN_SZ-1:0]      len_q [DEPTH];
    logic [LEN_SZ-1:0]      len_d [DEPTH];
    logic [PTR_SZ-1:0]      wr_slot_q, wr_slot_d;
    logic [PTR_IN_SZ-1:0]   cnt_q, cnt_d;
    logic                   commit_vld_q, commit_vld_d;
    logic [PTR_SZ-1:0]      commit_slot_q, commit_slot_d;
    logic [LEN_SZ-1:0]      commit_len_q, commit_len_d;
    logic                   wr_trunc_q, wr_trunc_d;
    logic                   rel_err_q, rel_err_d;

    logic [MEM_W-1:0]       mem_q [DEPTH][WIDTH];
    logic                   mem_we;
    logic [MEM_W-1:0]       mem_wdata;

    logic                   alloc_found;
    logic [PTR_SZ-1:0]      alloc_idx;
    logic                   last_byte;

    pkt_buf_slot_alloc #(
        .DEPTH  (DEPTH),
        .PTR_SZ (PTR_SZ)
    ) u_slot_alloc (
        .slot_state (slot_state_q),
        .found      (alloc_found),
        .idx        (alloc_idx)
    );

    // Write FSM, slot lifecycle, commit reporting and release handling.
    always_comb begin
        wr_state_d    = wr_state_q;
        slot_state_d  = slot_state_q;
        len_d         = len_q;
        wr_slot_d     = wr_slot_q;
        cnt_d         = cnt_q;
        commit_vld_d  = 1'b0;
        commit_slot_d = commit_slot_q;
        commit_len_d  = commit_len_q;
        wr_trunc_d    = 1'b0;
        rel_err_d     = 1'b0;
        wr_ready      = 1'b0;
        last_byte     = 1'b0;
        mem_we        = 1'b0;
`ifdef PKT_BUF_PARITY_EN
        mem_wdata     = {^wr_data, wr_data};
`else
        mem_wdata     = wr_data;
`endif

        case (wr_state_q)
            ALLOC: begin
                if (alloc_found) begin
                    slot_state_d[alloc_idx] = FILLING;
                    wr_slot_d               = alloc_idx;
                    cnt_d                   = '0;
                    wr_state_d              = FILL;
                end
            end
            FILL: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    mem_we    = 1'b1;
                    last_byte = wr_last || (cnt_q == CNT_LAST);
                    if (last_byte) begin
                        slot_state_d[wr_slot_q] = COMMITTED;
                        len_d[wr_slot_q]        = LEN_SZ'(cnt_q) + LEN_SZ'(1);
                        commit_vld_d            = 1'b1;
                        commit_slot_d           = wr_slot_q;
                        commit_len_d            = LEN_SZ'(cnt_q) + LEN_SZ'(1);
                        wr_trunc_d              = (cnt_q == CNT_LAST) && !wr_last;
                        wr_state_d              = ALLOC;
                    end else begin
                        cnt_d = cnt_q + PTR_IN_SZ'(1);
                    end
                end
            end
            default: wr_state_d = ALLOC;
        endcase

        // Only COMMITTED slots can be released, so a release never collides
        // with the allocate (FREE) or commit (FILLING) updates above.
        if (rel_en) begin
            if (slot_state_q[rel_slot] == COMMITTED) begin
                slot_state_d[rel_slot] = FREE;
            end else begin
                rel_err_d = 1'b1;
            end
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its _d value from before this edge, independent of order.
        if (!reset_n) begin
            wr_state_q    <= ALLOC;
            wr_slot_q     <= '0;
            cnt_q         <= '0;
            commit_vld_q  <= 1'b0;
            commit_slot_q <= '0;
            commit_len_q  <= '0;
            wr_trunc_q    <= 1'b0;
            rel_err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_state_q[i] <= FREE;
                len_q[i]        <= '0;
            end
        end else begin
            wr_state_q    <= wr_state_d;
            wr_slot_q     <= wr_slot_d;
            cnt_q         <= cnt_d;
            commit_vld_q  <= commit_vld_d;
            commit_slot_q <= commit_slot_d;
            commit_len_q  <= commit_len_d;
            wr_trunc_q    <= wr_trunc_d;
            rel_err_q     <= rel_err_d;
            slot_state_q  <= slot_state_d;
            len_q         <= len_d;
        end
    end

    // Packet byte storage, written one byte per accepted write beat.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; slot state and length gate
        // every read, so stale bytes are never visible after reset.
        if (mem_we) begin
            mem_q[wr_slot_q][cnt_q] <= mem_wdata;
        end
    end

    // Occupancy: count of FREE slots straight from the slot state registers,
    // so commit and release in the same cycle net out automatically.
    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_state_q[i] == FREE) begin
                free_cnt = free_cnt + (PTR_SZ + 1)'(1);
            end
        end
    end

    assign full        = (free_cnt == '0);
    assign wr_slot     = wr_slot_q;
    assign commit_vld  = commit_vld_q;
    assign commit_slot = commit_slot_q;
    assign commit_len  = commit_len_q;
    assign wr_trunc    = wr_trunc_q;
    assign rel_err     = rel_err_q;

    // Independent read ports, each with a registered data/valid pair.
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [PTR_SZ-1:0]    slot;
        logic [PTR_IN_SZ-1:0] idx;
        logic [MEM_W-1:0]     word;
        logic                 hit;
        logic [UWIDTH-1:0]    data_q, data_d;
        logic                 valid_q, valid_d;

        assign slot = rd_slot[p*PTR_SZ +: PTR_SZ];
        assign idx  = rd_idx[p*PTR_IN_SZ +: PTR_IN_SZ];

        // Hit check against pre-edge slot state; data holds when idle.
        always_comb begin
            word    = mem_q[slot][idx];
            hit     = rd_en[p] && (slot_state_q[slot] == COMMITTED) &&
                      (LEN_SZ'(idx) < len_q[slot]);
            valid_d = hit;
            data_d  = data_q;
            if (rd_en[p]) begin
                data_d = hit ? word[UWIDTH-1:0] : '0;
            end
        end

        // Read output registers.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign rd_data[p*UWIDTH +: UWIDTH] = data_q;
        assign rd_valid[p]                 = valid_q;

`ifdef PKT_BUF_PARITY_EN
        logic perr_q, perr_d;

        // Even parity over data plus stored parity bit must reduce to zero.
        always_comb begin
            perr_d = hit && (^word);
        end

        // Parity error register, aligned with rd_valid.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                perr_q <= 1'b0;
            end else begin
                perr_q <= perr_d;
            end
        end

        assign rd_perr[p] = perr_q;
`endif
    end

endmodule : router_packet_buffer

// File: tb/tb_router_packet_buffer.sv
// Self-checking bench for router_packet_buffer (default parameters).
// A small reference model of slot state, lengths and contents produces the
// expected commit and read results, queued when stimulus is driven and
// compared when the DUT presents them.
module tb_router_packet_buffer;

    localparam int DEPTH     = 4;
    localparam int WIDTH     = 11;
    localparam int UWIDTH    = 8;
    localparam int NRD       = 3;
    localparam int PTR_SZ    = 2;
    localparam int PTR_IN_SZ = 4;
    localparam int LEN_SZ    = 4;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     wr_valid;
    logic [UWIDTH-1:0]        wr_data;
    logic                     wr_last;
    logic                     wr_ready;
    logic [PTR_SZ-1:0]        wr_slot;
    logic                     commit_vld;
    logic [PTR_SZ-1:0]        commit_slot;
    logic [LEN_SZ-1:0]        commit_len;
    logic                     wr_trunc;
    logic [NRD-1:0]           rd_en;
    logic [NRD*PTR_SZ-1:0]    rd_slot;
    logic [NRD*PTR_IN_SZ-1:0] rd_idx;
    logic [NRD*UWIDTH-1:0]    rd_data;
    logic [NRD-1:0]           rd_valid;
`ifdef PKT_BUF_PARITY_EN
    logic [NRD-1:0]           rd_perr;
`endif
    logic                     rel_en;
    logic [PTR_SZ-1:0]        rel_slot;
    logic                     rel_err;
    logic [PTR_SZ:0]          free_cnt;
    logic                     full;

    always #5 clk = ~clk;

    router_packet_buffer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_last     (wr_last),
        .wr_ready    (wr_ready),
        .wr_slot     (wr_slot),
        .commit_vld  (commit_vld),
        .commit_slot (commit_slot),
        .commit_len  (commit_len),
        .wr_trunc    (wr_trunc),
        .rd_en       (rd_en),
        .rd_slot     (rd_slot),
        .rd_idx      (rd_idx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
`ifdef PKT_BUF_PARITY_EN
        .rd_perr     (rd_perr),
`endif
        .rel_en      (rel_en),
        .rel_slot    (rel_slot),
        .rel_err     (rel_err),
        .free_cnt    (free_cnt),
        .full        (full)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [PTR_SZ-1:0] slot;
        logic [LEN_SZ-1:0] len;
        logic              trunc;
    } commit_t;

    typedef struct packed {
        logic              valid;
        logic [UWIDTH-1:0] data;
    } rd_exp_t;

    commit_t commit_q [$];
    rd_exp_t rd_q     [$];
    commit_t mon_e;

    // Reference model: 0 = FREE, 1 = FILLING, 2 = COMMITTED
    int                m_state [DEPTH];
    int                m_len   [DEPTH];
    logic [UWIDTH-1:0] m_mem   [DEPTH][WIDTH];
    logic [UWIDTH-1:0] m_rd    [NRD];
    int                m_slot;
    int                m_cnt;
    bit                m_open;

    function automatic int lowest_free();
        for (int i = 0; i < DEPTH; i++) begin
            if (m_state[i] == 0) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_state[i] = 0;
            m_len[i]   = 0;
        end
        for (int p = 0; p < NRD; p++) m_rd[p] = '0;
        m_open = 1'b0;
        m_cnt  = 0;
        m_slot = 0;
    endtask

    // Commit scoreboard: every commit pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && commit_vld === 1'b1) begin
            checks++;
            if (commit_q.size() == 0) begin
                failures++;
                $display("FAIL commit_unexpected got slot=%0d len=%0d trunc=%0d expected none",
                         commit_slot, commit_len, wr_trunc);
            end else begin
                mon_e = commit_q.pop_front();
                if ({commit_slot, commit_len, wr_trunc} !== {mon_e.slot, mon_e.len, mon_e.trunc}) begin
                    failures++;
                    $display("FAIL commit got slot=%0d len=%0d trunc=%0d expected slot=%0d len=%0d trunc=%0d",
                             commit_slot, commit_len, wr_trunc, mon_e.slot, mon_e.len, mon_e.trunc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stream n bytes first, first+1, ... ; wr_last on the final byte if asked.
    task automatic send_seq(input logic [7:0] first, input int n, input logic last_at_end);
        for (int k = 0; k < n; k++) begin
            logic [7:0] b;
            logic       lst;
            int         waited;
            b      = first + 8'(k);
            lst    = last_at_end && (k == n - 1);
            waited = 0;
            if (!m_open) begin
                m_slot = lowest_free();
                if (m_slot < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL send_no_free_slot got none expected a free slot");
                    return;
                end
                m_state[m_slot] = 1;
                m_cnt           = 0;
                m_open          = 1'b1;
            end
            wr_valid = 1'b1;
            wr_data  = b;
            wr_last  = lst;
            while (wr_ready !== 1'b1 && waited < 40) begin
                @(posedge clk); #1;
                waited++;
            end
            if (wr_ready !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL wr_ready_timeout got wr_ready=%b expected 1 within 40 cycles", wr_ready);
                wr_valid = 1'b0;
                return;
            end
            checks++;
            if (wr_slot !== PTR_SZ'(m_slot)) begin
                failures++;
                $display("FAIL wr_slot got %0d expected %0d", wr_slot, m_slot);
            end
            m_mem[m_slot][m_cnt] = b;
            if (lst || m_cnt == WIDTH - 1) begin
                m_state[m_slot] = 2;
                m_len[m_slot]   = m_cnt + 1;
                commit_q.push_back('{slot: PTR_SZ'(m_slot), len: LEN_SZ'(m_cnt + 1),
                                     trunc: (m_cnt == WIDTH - 1) && !lst});
                m_open = 1'b0;
            end else begin
                m_cnt++;
            end
            @(posedge clk); #1;
            wr_valid = 1'b0;
            wr_last  = 1'b0;
        end
    endtask

    // One cycle of read and/or release traffic, checked against the model.
    task automatic do_cycle(input logic [NRD-1:0] en, input logic [NRD*PTR_SZ-1:0] slots,
                            input logic [NRD*PTR_IN_SZ-1:0] idxs, input logic rel,
                            input logic [PTR_SZ-1:0] rslot, input string tag);
        logic    exp_err;
        rd_exp_t e;
        rd_en    = en;
        rd_slot  = slots;
        rd_idx   = idxs;
        rel_en   = rel;
        rel_slot = rslot;
        for (int p = 0; p < NRD; p++) begin
            int  s;
            int  i;
            logic hit;
            s   = int'(slots[p*PTR_SZ +: PTR_SZ]);
            i   = int'(idxs[p*PTR_IN_SZ +: PTR_IN_SZ]);
            hit = en[p] && (m_state[s] == 2) && (i < m_len[s]);
            if (en[p]) begin
                if (hit) m_rd[p] = m_mem[s][i];
                else     m_rd[p] = '0;
            end
            rd_q.push_back('{valid: hit, data: m_rd[p]});
        end
        exp_err = rel && (m_state[rslot] != 2);
        @(posedge clk); #1;
        if (rel && !exp_err) m_state[rslot] = 0;
        rd_en  = '0;
        rel_en = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            e = rd_q.pop_front();
            checks++;
            if ({rd_valid[p], rd_data[p*UWIDTH +: UWIDTH]} !== {e.valid, e.data}) begin
                failures++;
                $display("FAIL %s_rd%0d got valid=%b data=%h expected valid=%b data=%h",
                         tag, p, rd_valid[p], rd_data[p*UWIDTH +: UWIDTH], e.valid, e.data);
            end
        end
        checks++;
        if (rel_err !== exp_err) begin
            failures++;
            $display("FAIL %s_rel_err got %b expected %b", tag, rel_err, exp_err);
        end
    endtask

    task automatic expect_ctl(input string tag, input logic [PTR_SZ:0] exp_free,
                              input logic exp_full, input logic exp_ready);
        checks++;
        if ({free_cnt, full, wr_ready} !== {exp_free, exp_full, exp_ready}) begin
            failures++;
            $display("FAIL %s got free_cnt=%0d full=%b wr_ready=%b expected free_cnt=%0d full=%b wr_ready=%b",
                     tag, free_cnt, full, wr_ready, exp_free, exp_full, exp_ready);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        expect_ctl("reset_ctl", 3'd4, 1'b0, 1'b0);
        checks++;
        if ({commit_vld, wr_trunc, rel_err, rd_valid, rd_data, wr_slot} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got cv=%b tr=%b re=%b rv=%b rd=%h ws=%0d expected all zero",
                     commit_vld, wr_trunc, rel_err, rd_valid, rd_data, wr_slot);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({wr_ready, wr_slot} !== {1'b1, 2'd0}) begin
            failures++;
            $display("FAIL reset_first_alloc got ready=%b slot=%0d expected ready=1 slot=0", wr_ready, wr_slot);
        end
    endtask

    task automatic test_basic();
        send_seq(8'hA1, 3, 1'b1);
        do_cycle(3'b011, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd1, 4'd0}, 1'b0, 2'd0, "basic");
    endtask

    task automatic test_full();
        send_seq(8'h10, 2, 1'b1);
        send_seq(8'h20, 5, 1'b1);
        send_seq(8'h30, 1, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        expect_ctl("full_ctl", 3'd0, 1'b1, 1'b0);
        do_cycle(3'b000, '0, '0, 1'b1, 2'd2, "rel2");
        expect_ctl("rel2_free", 3'd1, 1'b0, 1'b0);
        @(posedge clk); #1;
        expect_ctl("rel2_alloc", 3'd0, 1'b1, 1'b1);
        checks++;
        if (wr_slot !== 2'd2) begin
            failures++;
            $display("FAIL rel2_wr_slot got %0d expected 2", wr_slot);
        end
    endtask

    task automatic test_trunc();
        do_cycle(3'b000, '0, '0, 1'b1, 2'd3, "rel3");
        send_seq(8'h00, 12, 1'b0);
        send_seq(8'h0C, 1, 1'b1);
        do_cycle(3'b111, {2'd3, 2'd2, 2'd3}, {4'd1, 4'd10, 4'd0}, 1'b0, 2'd0, "trunc");
        checks++;
        if (rd_data[UWIDTH-1:0] !== 8'h0B) begin
            failures++;
            $display("FAIL trunc_spill_byte got %h expected 0b", rd_data[UWIDTH-1:0]);
        end
    endtask

    task automatic test_read_release();
        do_cycle(3'b111, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd0}, 1'b1, 2'd0, "rdrel_hit");
        do_cycle(3'b111, {2'd0, 2'd0, 2'd0}, {4'd0, 4'd0, 4'd0}, 1'b0, 2'd0, "rdrel_miss");
    endtask

    task automatic test_rel_err();
        do_cycle(3'b000, '0, '0, 1'b1, 2'd1, "rel1");
        expect_ctl("rel1_free", 3'd1, 1'b0, 1'b1);
        do_cycle(3'b000, '0, '0, 1'b1, 2'd1, "rel_free_slot");
        expect_ctl("rel_err_free", 3'd1, 1'b0, 1'b1);
        do_cycle(3'b000, '0, '0, 1'b0, 2'd0, "rel_err_drop");
        send_seq(8'hB1, 3, 1'b1);
        do_cycle(3'b111, {2'd1, 2'd0, 2'd0}, {4'd0, 4'd2, 4'd5}, 1'b0, 2'd0, "len_bound");
    endtask

    task automatic test_reset_mid_packet();
        send_seq(8'hC1, 2, 1'b0);
        reset_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        expect_ctl("midrst_ctl", 3'd4, 1'b0, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        send_seq(8'hD1, 1, 1'b1);
        do_cycle(3'b011, {2'd0, 2'd2, 2'd0}, {4'd0, 4'd0, 4'd0}, 1'b0, 2'd0, "midrst");
    endtask

    task automatic test_back_to_back();
        send_seq(8'hE1, 2, 1'b1);
        checks++;
        if (wr_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle got wr_ready=%b expected 0", wr_ready);
        end
        @(posedge clk); #1;
        checks++;
        if ({wr_ready, wr_slot} !== {1'b1, 2'd2}) begin
            failures++;
            $display("FAIL b2b_reopen got ready=%b slot=%0d expected ready=1 slot=2", wr_ready, wr_slot);
        end
        send_seq(8'hF1, 1, 1'b1);
        do_cycle(3'b101, {2'd2, 2'd0, 2'd1}, {4'd0, 4'd0, 4'd1}, 1'b0, 2'd0, "b2b");
    endtask

`ifdef PKT_BUF_PARITY_EN
    task automatic test_parity();
        dut.mem_q[0][0][UWIDTH] = ~dut.mem_q[0][0][UWIDTH];
        rd_en   = 3'b001;
        rd_slot = '0;
        rd_idx  = '0;
        @(posedge clk); #1;
        rd_en = '0;
        m_rd[0] = m_mem[0][0];
        checks++;
        if ({rd_valid[0], rd_perr[0]} !== 2'b11) begin
            failures++;
            $display("FAIL parity got valid=%b perr=%b expected valid=1 perr=1", rd_valid[0], rd_perr[0]);
        end
    endtask
`endif

    initial begin
        reset_n  = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        wr_last  = 1'b0;
        rd_en    = '0;
        rd_slot  = '0;
        rd_idx   = '0;
        rel_en   = 1'b0;
        rel_slot = '0;
        model_reset();

        test_reset();
        test_basic();
        test_full();
        test_trunc();
        test_read_release();
        test_rel_err();
        test_reset_mid_packet();
        test_back_to_back();
`ifdef PKT_BUF_PARITY_EN
        test_parity();
`endif

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (commit_q.size() != 0) begin
            failures++;
            $display("FAIL commits_outstanding got %0d pending expected 0", commit_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_router_packet_buffer
